// File: rtl/d_hazard_ctrl.sv
// rtl/d_hazard_ctrl.sv - decode-stage hazard control for the 5-stage F/D/X/M/W core
//
// Purpose:
//   Tracks the destinations of the instructions in X, M and W in a small
//   shadow scoreboard. From it the block produces:
//     - operand bypass selects for D,
//     - load-use stalls,
//     - redirect flushes,
//     - a whole-pipe freeze while the data memory is busy.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   d_valid             valid instruction in D
//   d_rs1, d_rs2        D source registers
//   d_rs1_used/_used    D actually reads rs1 / rs2
//   d_rd, d_rf_wr_en    D destination and write enable
//   d_is_load           D is a load
//   x_redirect          taken branch/jump resolved in X
//   dmem_busy           M-stage memory not ready, whole pipe holds
//   f_stall, d_stall    hold PC+F/D, hold D
//   fd_flush            bubble into F/D
//   dx_bubble           bubble into D/X
//   fwd_a_sel/fwd_b_sel 0 regfile, 1 X, 2 M, 3 W
//   stall_cnt           saturating count of load-use stall cycles
//   flush_cnt           saturating count of redirect flushes
module d_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_rs1_used,
  input  logic              d_rs2_used,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_rf_wr_en,
  input  logic              d_is_load,
  input  logic              x_redirect,
  input  logic              dmem_busy,
  output logic              f_stall,
  output logic              d_stall,
  output logic              fd_flush,
  output logic              dx_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_x_vld, r_x_wr, r_x_ld;
  logic [REG_AW-1:0] r_x_rd;
  logic              r_m_vld, r_m_wr, r_m_ld;
  logic [REG_AW-1:0] r_m_rd;
  logic              r_w_vld, r_w_wr, r_w_ld;
  logic [REG_AW-1:0] r_w_rd;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_advance, w_load_use, w_stall_evt, w_flush_evt;
  logic w_f_stall, w_d_stall, w_fd_flush, w_dx_bubble;

  // x0 is hardwired zero, so a write to it never produces a hit.
  function automatic logic f_hit(input logic vld, input logic wr,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] r);
    return vld & wr & (rd == r) & (r != '0);
  endfunction

  // Youngest producer wins: X over M over W.
  function automatic logic [1:0] f_sel(input logic used, input logic [REG_AW-1:0] r);
    if (!used)                               return 2'd0;
    else if (f_hit(r_x_vld, r_x_wr, r_x_rd, r)) return 2'd1;
    else if (f_hit(r_m_vld, r_m_wr, r_m_rd, r)) return 2'd2;
    else if (f_hit(r_w_vld, r_w_wr, r_w_rd, r)) return 2'd3;
    else                                     return 2'd0;
  endfunction

  assign w_advance = !dmem_busy;

  // Load data only exists from M onward, so a consumer right behind a load
  // must wait exactly one cycle and then picks it up through the M bypass.
  assign w_load_use = d_valid & !x_redirect & r_x_ld &
                      ((d_rs1_used & f_hit(r_x_vld, r_x_wr, r_x_rd, d_rs1)) |
                       (d_rs2_used & f_hit(r_x_vld, r_x_wr, r_x_rd, d_rs2)));

  always_comb begin
    w_f_stall   = 1'b0;
    w_d_stall   = 1'b0;
    w_fd_flush  = 1'b0;
    w_dx_bubble = 1'b0;
    if (!rst) begin
      if (!w_advance) begin
        // Memory stall freezes everything; a pending redirect stays in X
        // and is taken once the pipe moves again.
        w_f_stall = 1'b1;
        w_d_stall = 1'b1;
      end else if (x_redirect) begin
        w_fd_flush  = 1'b1;
        w_dx_bubble = 1'b1;
      end else if (w_load_use) begin
        w_f_stall   = 1'b1;
        w_d_stall   = 1'b1;
        w_dx_bubble = 1'b1;
      end
    end
  end

  assign w_flush_evt = w_advance & x_redirect;
  assign w_stall_evt = w_advance & !x_redirect & w_load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_vld <= 1'b0; r_x_wr <= 1'b0; r_x_ld <= 1'b0; r_x_rd <= '0;
      r_m_vld <= 1'b0; r_m_wr <= 1'b0; r_m_ld <= 1'b0; r_m_rd <= '0;
      r_w_vld <= 1'b0; r_w_wr <= 1'b0; r_w_ld <= 1'b0; r_w_rd <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_advance) begin
      r_w_vld <= r_m_vld; r_w_wr <= r_m_wr; r_w_ld <= r_m_ld; r_w_rd <= r_m_rd;
      r_m_vld <= r_x_vld; r_m_wr <= r_x_wr; r_m_ld <= r_x_ld; r_m_rd <= r_x_rd;
      r_x_vld <= d_valid & !w_dx_bubble;
      r_x_wr  <= d_rf_wr_en;
      r_x_ld  <= d_is_load;
      r_x_rd  <= d_rd;
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign f_stall   = w_f_stall;
  assign d_stall   = w_d_stall;
  assign fd_flush  = w_fd_flush;
  assign dx_bubble = w_dx_bubble;
  assign fwd_a_sel = rst ? 2'd0 : f_sel(d_rs1_used, d_rs1);
  assign fwd_b_sel = rst ? 2'd0 : f_sel(d_rs2_used, d_rs2);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// tb/tb_d_hazard_ctrl.sv - directed self-checking bench for d_hazard_ctrl
module tb_d_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              d_valid, d_rs1_used, d_rs2_used, d_rf_wr_en, d_is_load;
  logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
  logic              x_redirect, dmem_busy;
  logic              f_stall, d_stall, fd_flush, dx_bubble;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [3:0]        ctl;

  int n_cmp = 0;
  int n_bad = 0;

  d_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_rd(d_rd), .d_rf_wr_en(d_rf_wr_en), .d_is_load(d_is_load),
    .x_redirect(x_redirect), .dmem_busy(dmem_busy),
    .f_stall(f_stall), .d_stall(d_stall), .fd_flush(fd_flush), .dx_bubble(dx_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {f_stall, d_stall, fd_flush, dx_bubble}
  assign ctl = {f_stall, d_stall, fd_flush, dx_bubble};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld);
    d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_rs1_used = u1; d_rs2_used = u2;
    d_rd = rd; d_rf_wr_en = wr; d_is_load = ld;
    #1;
  endtask

  // Push a writer of rd into X (load if ld=1).
  task automatic issue(input logic [4:0] rd, input logic ld);
    x_redirect = 1'b0; dmem_busy = 1'b0;
    set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, ld);
    tick;
  endtask

  task automatic bubble;
    x_redirect = 1'b0; dmem_busy = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_redirect = 1'($urandom); dmem_busy = 1'($urandom);
      set_d(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom));
      tick;
      n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
      n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL reset_sel: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
      n_cmp++; if ({stall_cnt, flush_cnt} !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    end
    rst = 1'b0; x_redirect = 1'b0; dmem_busy = 1'b0;
    set_d(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if ({ctl, fwd_a_sel, fwd_b_sel} !== 8'h00) begin n_bad++; $display("FAIL idle_out: got %h want 00", {ctl, fwd_a_sel, fwd_b_sel}); end
      tick;
    end
  endtask

  task automatic test_fwd_priority;
    issue(5'd5, 1'b0); issue(5'd5, 1'b0); issue(5'd5, 1'b0);
    set_d(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin n_bad++; $display("FAIL fwd_x: got %b want 0101", {fwd_a_sel, fwd_b_sel}); end
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL fwd_x_ctl: got %b want 0000", ctl); end
    issue(5'd5, 1'b0); issue(5'd5, 1'b0); bubble;
    set_d(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin n_bad++; $display("FAIL fwd_m: got %b want 1010", {fwd_a_sel, fwd_b_sel}); end
    issue(5'd5, 1'b0); bubble; bubble;
    set_d(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1111) begin n_bad++; $display("FAIL fwd_w: got %b want 1111", {fwd_a_sel, fwd_b_sel}); end
    issue(5'd0, 1'b0); issue(5'd0, 1'b0); issue(5'd0, 1'b0);
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL fwd_x0: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_load_use;
    issue(5'd7, 1'b1);
    set_d(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL lu_ctl: got %b want 1101", ctl); end
    n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
    tick;
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL lu_after_ctl: got %b want 0000", ctl); end
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin n_bad++; $display("FAIL lu_after_sel: got %b want 1000", {fwd_a_sel, fwd_b_sel}); end
    n_cmp++; if (stall_cnt !== 3'd1) begin n_bad++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_redirect;
    issue(5'd7, 1'b1);
    x_redirect = 1'b1;
    set_d(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL rd_ctl: got %b want 0011", ctl); end
    tick;
    x_redirect = 1'b0;
    #1;
    n_cmp++; if ({stall_cnt, flush_cnt} !== {3'd1, 3'd1}) begin n_bad++; $display("FAIL rd_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt); end
    n_cmp++; if ({ctl, fwd_a_sel} !== 6'b000010) begin n_bad++; $display("FAIL rd_xbubble: got %b want 000010", {ctl, fwd_a_sel}); end
  endtask

  task automatic test_backpressure;
    issue(5'd10, 1'b0);
    dmem_busy = 1'b1; x_redirect = 1'b1;
    set_d(1'b1, 5'd10, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL bp_ctl[%0d]: got %b want 1100", i, ctl); end
      n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0111) begin n_bad++; $display("FAIL bp_sel[%0d]: got %b want 0111", i, {fwd_a_sel, fwd_b_sel}); end
      n_cmp++; if ({stall_cnt, flush_cnt} !== {3'd1, 3'd1}) begin n_bad++; $display("FAIL bp_cnt[%0d]: got %0d/%0d want 1/1", i, stall_cnt, flush_cnt); end
      tick;
    end
    dmem_busy = 1'b0;
    #1;
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL bp_release_ctl: got %b want 0011", ctl); end
    tick;
    x_redirect = 1'b0;
    #1;
    n_cmp++; if (flush_cnt !== 3'd2) begin n_bad++; $display("FAIL bp_flush_cnt: got %0d want 2", flush_cnt); end
    n_cmp++; if ({ctl, fwd_a_sel, fwd_b_sel} !== 8'b0000_1000) begin n_bad++; $display("FAIL bp_shift: got %b want 00001000", {ctl, fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_unused_operand;
    issue(5'd9, 1'b1);
    set_d(1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    n_cmp++; if ({ctl, fwd_a_sel, fwd_b_sel} !== 8'h00) begin n_bad++; $display("FAIL unused: got %b want 00000000", {ctl, fwd_a_sel, fwd_b_sel}); end
    n_cmp++; if (stall_cnt !== 3'd1) begin n_bad++; $display("FAIL unused_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_saturation;
    x_redirect = 1'b1; dmem_busy = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick;
    n_cmp++; if (flush_cnt !== 3'd7) begin n_bad++; $display("FAIL flush_sat: got %0d want 7", flush_cnt); end
    for (int i = 0; i < 7; i++) begin
      issue(5'd9, 1'b1);
      set_d(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
      if (i == 6) begin
        n_cmp++; if (ctl !== 4'b1101) begin n_bad++; $display("FAIL sat_lu_ctl: got %b want 1101", ctl); end
      end
      tick;
    end
    n_cmp++; if ({stall_cnt, flush_cnt} !== {3'd7, 3'd7}) begin n_bad++; $display("FAIL stall_sat: got %0d/%0d want 7/7", stall_cnt, flush_cnt); end
  endtask

  initial begin
    test_reset;
    test_fwd_priority;
    test_load_use;
    test_redirect;
    test_backpressure;
    test_unused_operand;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_hazard_ctrl.md
Name: d_hazard_ctrl

Overview:
- Pipeline control unit for the decode stage of the 5-stage core (F/D/X/M/W).
- Keeps a shadow scoreboard of in-flight destinations in X, M and W.
- From it, generates per-operand bypass selects for the D-stage opA/opB operand muxes, load-use stalls, redirect flushes and global freeze on data-memory backpressure.
- Sits beside the decode stage; consumes its decoded rs1/rs2/rd/rf_wr_en and drives the F/D pipeline-register enables.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- d_valid  in  1  valid instruction present in D.
- d_rs1  in  REG_AW  source register 1 of D instruction.
- d_rs2  in  REG_AW  source register 2 of D instruction.
- d_rs1_used  in  1  D instruction reads rs1 (0 for LUI/AUIPC/JAL).
- d_rs2_used  in  1  D instruction reads rs2 (1 only for RR/BRANCH/STORE).
- d_rd  in  REG_AW  destination register of D instruction.
- d_rf_wr_en  in  1  D instruction writes register file.
- d_is_load  in  1  D instruction is a LOAD.
- x_redirect  in  1  taken branch/jump resolved in X.
- dmem_busy  in  1  M-stage memory not ready; whole pipe must hold.
- f_stall  out  1  hold PC and F/D register.
- d_stall  out  1  hold D instruction (do not advance to X).
- fd_flush  out  1  replace F/D register contents with a bubble.
- dx_bubble  out  1  insert a bubble into the D/X register.
- fwd_a_sel  out  2  opA source: 0 = regfile, 1 = X result, 2 = M result, 3 = W result.
- fwd_b_sel  out  2  opB source, same encoding as fwd_a_sel.
- stall_cnt  out  CNT_W  cycles with a load-use stall.
- flush_cnt  out  CNT_W  redirect flushes taken.

Behaviour:
- State: three scoreboard entries X, M, W, each holding {vld, rd, wr, ld}.
- Reset (rst=1 at posedge):
  - All entries have vld=0.
  - Counters are 0.
  - Reset overrides every other input in the same cycle.
- Outputs are combinational from current state and inputs. While rst is asserted, the state is the reset state, so outputs are 0 except the forwarding selects, which are also 0.
- advance = !dmem_busy.
  - When advance=0: X/M/W entries hold; f_stall=d_stall=1; fd_flush=dx_bubble=0; counters hold.
  - x_redirect is ignored while dmem_busy. X holds the branch, so redirect is acted on in the first cycle dmem_busy=0.
- hit_S(r) = S.vld & S.wr & (S.rd==r) & (r!=0), for S in X, M, W.
- Forward select for rs1 (rs2 identical):
  - 0 if !d_rs1_used.
  - Otherwise priority X(1) > M(2) > W(3) > regfile(0).
  - Selects are valid regardless of d_valid.
- load_use = d_valid & !x_redirect & X.ld & ((d_rs1_used & hit_X(d_rs1)) | (d_rs2_used & hit_X(d_rs2))).
  - Load data is forwardable from M (sel=2) onward, so exactly one stall cycle is required.
- Priority when advance=1:
  1. x_redirect:
     - fd_flush=1, dx_bubble=1, f_stall=0, d_stall=0.
     - flush_cnt increments; load_use is suppressed.
  2. load_use:
     - f_stall=1, d_stall=1, dx_bubble=1, fd_flush=0.
     - stall_cnt increments.
  3. Otherwise: all control outputs 0.
- Shift on advance:
  - W<=M, M<=X.
  - X <= bubble (vld=0) if dx_bubble or !d_valid.
  - Else X <= {1, d_rd, d_rf_wr_en, d_is_load}.
- Counters saturate at all-ones; no wrap-around.
- rd=0 never forwards and never causes a stall, even when wr=1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with random inputs -> all control outputs 0, fwd sels 0, counters 0; after release with d_valid=0, outputs stay 0.
- Forward priority:
  - Sequence: `addi x5` (W), `addi x5` (M), `addi x5` (X); D=`add x6,x5,x5` -> fwd_a_sel=fwd_b_sel=1.
  - Kill the X entry -> both sels 2.
  - Kill X and M entries -> both sels 3.
  - Same sequence with rd=x0 and D=`add x6,x0,x0` -> sels 0.
- Load-use: `lw x7` in X, D=`add x8,x7,x1` -> one cycle f_stall=d_stall=dx_bubble=1, stall_cnt=1; next cycle no stall, fwd_a_sel=2.
- Redirect over load-use: load-use condition plus x_redirect=1 -> fd_flush=dx_bubble=1, f_stall=0, flush_cnt=1, stall_cnt unchanged; next cycle X.vld=0.
- Memory backpressure:
  - dmem_busy=1 for 3 cycles with x_redirect=1 -> f_stall=d_stall=1, no flush, scoreboard and counters frozen.
  - Cycle dmem_busy drops -> flush taken, flush_cnt+1.
- Unused operand: `lui x9` in D with rs1 field = X.rd of a load in X, d_rs1_used=0 -> no stall, fwd_a_sel=0.
